// File: rtl/ysyx_24100005_lsu_pkg.sv
// Shared types and helpers for the NPC load/store unit and its lane aligner.
// Also intended for the future data cache.
package ysyx_24100005_lsu_pkg;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_WAIT = 3'd2;
  localparam logic [2:0] ST_RESP = 3'd3;
  localparam logic [2:0] ST_ERR  = 3'd4;

  typedef enum logic [2:0] {
    IDLE = ST_IDLE,
    REQ  = ST_REQ,
    WAIT = ST_WAIT,
    RESP = ST_RESP,
    ERR  = ST_ERR
  } state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    return 4'd1 << funct3[1:0];
  endfunction

  // Only the low three address bits matter for alignment up to 8 bytes.
  function automatic logic is_legal(input logic [2:0] funct3, input logic wen,
                                    input logic [2:0] addr_lo, input int xlen);
    logic [3:0] nbytes;
    logic       ok;
    nbytes = size_bytes(funct3);
    ok     = ((addr_lo & 3'(nbytes - 4'd1)) == 3'd0);
    if (xlen == 32 && (funct3 == F3_D || funct3 == F3_WU || funct3 == 3'b111)) ok = 1'b0;
    if (xlen == 64 && funct3 == 3'b111) ok = 1'b0;
    if (wen && funct3[2]) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/ysyx_24100005_lsu_align.sv
// Combinational byte-lane aligner: store mask/data placement and load
// extraction with sign or zero extension.
module ysyx_24100005_lsu_align
  import ysyx_24100005_lsu_pkg::*;
#(
  parameter  int XLEN   = 32,
  localparam int MASK_W = XLEN / 8,
  localparam int OFF_W  = $clog2(MASK_W)
) (
  input  logic [2:0]        i_funct3,
  input  logic [OFF_W-1:0]  i_off,
  input  logic [XLEN-1:0]   i_st_data,
  input  logic [XLEN-1:0]   i_ld_data,
  output logic [MASK_W-1:0] o_wmask,
  output logic [XLEN-1:0]   o_wdata,
  output logic [XLEN-1:0]   o_ld_data
);

  logic [3:0]       w_nbytes;
  logic [MASK_W-1:0] w_size_mask;
  logic [XLEN-1:0]  w_bit_mask;
  logic [XLEN-1:0]  w_ld_sh;
  logic [OFF_W+2:0] w_shamt;
  logic             w_sign;

  always_comb begin
    w_nbytes = size_bytes(i_funct3);
    for (int i = 0; i < MASK_W; i++) begin
      w_size_mask[i]       = (4'(i) < w_nbytes);
      w_bit_mask[i*8 +: 8] = {8{w_size_mask[i]}};
    end
    w_shamt   = {i_off, 3'b000};
    o_wmask   = w_size_mask << i_off;
    o_wdata   = (i_st_data & w_bit_mask) << w_shamt;
    w_ld_sh   = i_ld_data >> w_shamt;
    case (i_funct3[1:0])
      2'd0:    w_sign = w_ld_sh[7];
      2'd1:    w_sign = w_ld_sh[15];
      2'd2:    w_sign = w_ld_sh[31];
      default: w_sign = w_ld_sh[XLEN-1];
    endcase
    w_sign    = w_sign & ~i_funct3[2];
    // Keep the selected bytes, fill everything above with the sign.
    o_ld_data = (w_ld_sh & w_bit_mask) | ({XLEN{w_sign}} & ~w_bit_mask);
  end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Multi-cycle load/store unit: core request/response on one side, a single
// outstanding aligned memory transaction on the other.
module ysyx_24100005_lsu
  import ysyx_24100005_lsu_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int ADDR_W = 32,
  localparam int MASK_W = XLEN / 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wen,
  input  logic [2:0]        i_req_funct3,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [XLEN-1:0]   i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [XLEN-1:0]   o_resp_rdata,
  output logic              o_resp_err,
  output logic              o_mem_req_valid,
  input  logic              i_mem_req_ready,
  output logic              o_mem_req_wen,
  output logic [ADDR_W-1:0] o_mem_req_addr,
  output logic [XLEN-1:0]   o_mem_req_wdata,
  output logic [MASK_W-1:0] o_mem_req_wmask,
  input  logic              i_mem_rsp_valid,
  input  logic [XLEN-1:0]   i_mem_rsp_rdata,
  input  logic              i_mem_rsp_err
);

  localparam int OFF_W = $clog2(MASK_W);

  state_e            r_state;
  logic              r_wen;
  logic [2:0]        r_funct3;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic [XLEN-1:0]   r_rdata;
  logic              r_err;

  logic              w_legal;
  logic              w_in_req;
  logic [MASK_W-1:0] w_wmask;
  logic [XLEN-1:0]   w_wdata;
  logic [XLEN-1:0]   w_ld_data;

  assign w_legal = is_legal(i_req_funct3, i_req_wen, i_req_addr[2:0], XLEN);

  ysyx_24100005_lsu_align #(.XLEN(XLEN)) u_align (
    .i_funct3  (r_funct3),
    .i_off     (r_addr[OFF_W-1:0]),
    .i_st_data (r_wdata),
    .i_ld_data (i_mem_rsp_rdata),
    .o_wmask   (w_wmask),
    .o_wdata   (w_wdata),
    .o_ld_data (w_ld_data)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state  <= IDLE;
      r_wen    <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (i_req_valid) begin
          r_wen    <= i_req_wen;
          r_funct3 <= i_req_funct3;
          r_addr   <= i_req_addr;
          r_wdata  <= i_req_wdata;
          r_rdata  <= '0;
          r_err    <= ~w_legal;
          r_state  <= w_legal ? REQ : ERR;
        end
        REQ:  if (i_mem_req_ready) r_state <= WAIT;
        WAIT: if (i_mem_rsp_valid) begin
          r_err   <= i_mem_rsp_err;
          r_rdata <= (r_wen || i_mem_rsp_err) ? '0 : w_ld_data;
          r_state <= RESP;
        end
        RESP, ERR: if (i_resp_ready) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory-side fields are forced to zero outside REQ so idle buses stay quiet.
  assign w_in_req        = (r_state == REQ);
  assign o_req_ready     = (r_state == IDLE);
  assign o_mem_req_valid = w_in_req;
  assign o_mem_req_wen   = w_in_req & r_wen;
  assign o_mem_req_addr  = w_in_req ? {r_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign o_mem_req_wmask = !w_in_req ? '0 : (r_wen ? w_wmask : '1);
  assign o_mem_req_wdata = (w_in_req && r_wen) ? w_wdata : '0;
  assign o_resp_valid    = (r_state == RESP) || (r_state == ERR);
  assign o_resp_err      = o_resp_valid & r_err;
  assign o_resp_rdata    = o_resp_valid ? r_rdata : '0;

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Directed bench for the LSU: one RV32 instance for most scenarios and one
// RV64 instance for doubleword/word-in-doubleword loads.
module tb_ysyx_24100005_lsu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b0, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_wen;
  logic [31:0] mem_req_addr, mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid = 1'b0, mem_rsp_err = 1'b0;
  logic [31:0] mem_rsp_rdata = '0;

  logic        d_req_valid = 1'b0, d_req_ready, d_req_wen = 1'b0;
  logic [2:0]  d_req_funct3 = 3'd0;
  logic [31:0] d_req_addr = '0;
  logic [63:0] d_req_wdata = '0;
  logic        d_resp_valid, d_resp_ready = 1'b0, d_resp_err;
  logic [63:0] d_resp_rdata;
  logic        d_mem_req_valid, d_mem_req_ready = 1'b0, d_mem_req_wen;
  logic [31:0] d_mem_req_addr;
  logic [63:0] d_mem_req_wdata;
  logic [7:0]  d_mem_req_wmask;
  logic        d_mem_rsp_valid = 1'b0, d_mem_rsp_err = 1'b0;
  logic [63:0] d_mem_rsp_rdata = '0;

  int checks = 0;
  int errors = 0;

  // Observations from the last driven transaction.
  logic        t_ready_at_accept, t_saw_mem, t_mem_unstable, t_resp_unstable, t_req_ready_seen;
  logic        t_mem_wen, t_err, t_ready_after;
  logic [31:0] t_mem_addr, t_mem_wdata, t_rdata;
  logic [3:0]  t_mem_wmask;
  int          t_lat;
  logic [63:0] d_rdata;
  logic [31:0] d_addr;
  logic [7:0]  d_wmask;
  logic        d_err, d_saw_mem;

  always #5 clk = ~clk;

  ysyx_24100005_lsu #(.XLEN(32), .ADDR_W(32)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_wen(req_wen), .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .o_resp_valid(resp_valid), .i_resp_ready(resp_ready), .o_resp_rdata(resp_rdata), .o_resp_err(resp_err),
    .o_mem_req_valid(mem_req_valid), .i_mem_req_ready(mem_req_ready), .o_mem_req_wen(mem_req_wen),
    .o_mem_req_addr(mem_req_addr), .o_mem_req_wdata(mem_req_wdata), .o_mem_req_wmask(mem_req_wmask),
    .i_mem_rsp_valid(mem_rsp_valid), .i_mem_rsp_rdata(mem_rsp_rdata), .i_mem_rsp_err(mem_rsp_err)
  );

  ysyx_24100005_lsu #(.XLEN(64), .ADDR_W(32)) u_dut64 (
    .i_clk(clk), .i_rst(rst), .i_req_valid(d_req_valid), .o_req_ready(d_req_ready),
    .i_req_wen(d_req_wen), .i_req_funct3(d_req_funct3), .i_req_addr(d_req_addr), .i_req_wdata(d_req_wdata),
    .o_resp_valid(d_resp_valid), .i_resp_ready(d_resp_ready), .o_resp_rdata(d_resp_rdata), .o_resp_err(d_resp_err),
    .o_mem_req_valid(d_mem_req_valid), .i_mem_req_ready(d_mem_req_ready), .o_mem_req_wen(d_mem_req_wen),
    .o_mem_req_addr(d_mem_req_addr), .o_mem_req_wdata(d_mem_req_wdata), .o_mem_req_wmask(d_mem_req_wmask),
    .i_mem_rsp_valid(d_mem_rsp_valid), .i_mem_rsp_rdata(d_mem_rsp_rdata), .i_mem_rsp_err(d_mem_rsp_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one RV32 transaction with programmable stalls and records what it saw.
  task automatic run32(input logic wen, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] mrdata, input logic merr,
                       input int req_stall, input int rsp_delay, input int resp_stall);
    int  cyc, cnt, rcnt, phase;
    logic done;
    t_saw_mem = 0; t_mem_unstable = 0; t_resp_unstable = 0; t_req_ready_seen = 0;
    t_mem_addr = 'x; t_mem_wdata = 'x; t_mem_wmask = 'x; t_mem_wen = 'x;
    t_rdata = 'x; t_err = 'x; t_lat = -1;
    t_ready_at_accept = req_ready;
    req_valid = 1; req_wen = wen; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    tick();
    req_valid = 0;
    cyc = 1; cnt = 0; rcnt = 0; phase = 0; done = 0;
    while (!done && cyc < 60) begin
      if (req_ready) t_req_ready_seen = 1;
      mem_rsp_valid = 0; mem_rsp_err = 0;
      if (mem_req_valid) begin
        if (!t_saw_mem) begin
          t_mem_addr = mem_req_addr; t_mem_wdata = mem_req_wdata;
          t_mem_wmask = mem_req_wmask; t_mem_wen = mem_req_wen;
        end else if (mem_req_addr !== t_mem_addr || mem_req_wdata !== t_mem_wdata ||
                     mem_req_wmask !== t_mem_wmask || mem_req_wen !== t_mem_wen) begin
          t_mem_unstable = 1;
        end
        t_saw_mem = 1;
        if (cnt < req_stall) begin mem_req_ready = 0; cnt++; end
        else begin mem_req_ready = 1; phase = 1; cnt = 0; end
      end else begin
        mem_req_ready = 0;
        if (phase == 1) begin
          if (cnt < rsp_delay) cnt++;
          else begin mem_rsp_valid = 1; mem_rsp_rdata = mrdata; mem_rsp_err = merr; phase = 2; end
        end
      end
      if (resp_valid) begin
        if (t_lat < 0) begin t_lat = cyc; t_rdata = resp_rdata; t_err = resp_err; end
        else if (resp_rdata !== t_rdata || resp_err !== t_err) t_resp_unstable = 1;
        if (rcnt < resp_stall) begin resp_ready = 0; rcnt++; end
        else begin resp_ready = 1; done = 1; end
      end
      tick();
      cyc++;
    end
    resp_ready = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_err = 0;
    t_ready_after = req_ready;
  endtask

  // Drives one RV64 load with no stalls.
  task automatic run64(input logic [2:0] f3, input logic [31:0] addr, input logic [63:0] mrdata);
    int   cyc;
    logic pend, done;
    d_rdata = 'x; d_err = 'x; d_addr = 'x; d_wmask = 'x; d_saw_mem = 0;
    d_req_valid = 1; d_req_wen = 0; d_req_funct3 = f3; d_req_addr = addr;
    tick();
    d_req_valid = 0; d_mem_req_ready = 1;
    cyc = 0; pend = 0; done = 0;
    while (!done && cyc < 30) begin
      d_mem_rsp_valid = 0;
      if (pend) begin d_mem_rsp_valid = 1; d_mem_rsp_rdata = mrdata; pend = 0; end
      if (d_mem_req_valid) begin d_addr = d_mem_req_addr; d_wmask = d_mem_req_wmask; d_saw_mem = 1; pend = 1; end
      if (d_resp_valid) begin d_rdata = d_resp_rdata; d_err = d_resp_err; d_resp_ready = 1; done = 1; end
      tick();
      cyc++;
    end
    d_resp_ready = 0; d_mem_req_ready = 0; d_mem_rsp_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
    checks++; if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin errors++;
      $display("FAIL reset_resp: got valid=%b err=%b rdata=%h want 0", resp_valid, resp_err, resp_rdata); end
    checks++; if ({mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask} !== 70'd0) begin errors++;
      $display("FAIL reset_mem_req: got v=%b w=%b a=%h d=%h m=%h want 0", mem_req_valid, mem_req_wen,
               mem_req_addr, mem_req_wdata, mem_req_wmask); end
    @(negedge clk);
    rst = 0;
    tick();
  endtask

  task automatic test_store_word();
    run32(1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0, 0, 0, 0, 0);
    checks++; if (t_ready_at_accept !== 1'b1) begin errors++; $display("FAIL sw_req_ready: got %b want 1", t_ready_at_accept); end
    checks++; if (t_mem_addr !== 32'h8000_0004) begin errors++; $display("FAIL sw_addr: got %h want 80000004", t_mem_addr); end
    checks++; if (t_mem_wmask !== 4'b1111) begin errors++; $display("FAIL sw_wmask: got %b want 1111", t_mem_wmask); end
    checks++; if (t_mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", t_mem_wdata); end
    checks++; if (t_mem_wen !== 1'b1) begin errors++; $display("FAIL sw_wen: got %b want 1", t_mem_wen); end
    checks++; if (t_lat !== 3) begin errors++; $display("FAIL sw_latency: got %0d want 3", t_lat); end
    checks++; if ({t_err, t_rdata} !== 33'd0) begin errors++; $display("FAIL sw_resp: got err=%b rdata=%h want 0/0", t_err, t_rdata); end
    checks++; if (t_ready_after !== 1'b1) begin errors++; $display("FAIL sw_back_idle: got %b want 1", t_ready_after); end
  endtask

  task automatic test_store_lanes();
    run32(1, 3'b000, 32'h8000_0003, 32'h0000_00A5, 32'h0, 0, 0, 0, 0);
    checks++; if (t_mem_wmask !== 4'b1000) begin errors++; $display("FAIL sb_wmask: got %b want 1000", t_mem_wmask); end
    checks++; if (t_mem_wdata !== 32'hA500_0000) begin errors++; $display("FAIL sb_wdata: got %h want a5000000", t_mem_wdata); end
    checks++; if (t_mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL sb_addr: got %h want 80000000", t_mem_addr); end
    run32(1, 3'b001, 32'h8000_0002, 32'h1234_ABCD, 32'h0, 0, 0, 0, 0);
    checks++; if (t_mem_wmask !== 4'b1100) begin errors++; $display("FAIL sh_wmask: got %b want 1100", t_mem_wmask); end
    checks++; if (t_mem_wdata !== 32'hABCD_0000) begin errors++; $display("FAIL sh_wdata: got %h want abcd0000", t_mem_wdata); end
  endtask

  task automatic test_loads();
    run32(0, 3'b001, 32'h8000_0002, 32'h0, 32'h8123_4567, 0, 0, 0, 0);
    checks++; if (t_rdata !== 32'hFFFF_8123) begin errors++; $display("FAIL lh_rdata: got %h want ffff8123", t_rdata); end
    checks++; if (t_mem_wmask !== 4'b1111 || t_mem_wen !== 1'b0) begin errors++;
      $display("FAIL lh_read_req: got wmask=%b wen=%b want 1111/0", t_mem_wmask, t_mem_wen); end
    checks++; if (t_mem_addr !== 32'h8000_0000) begin errors++; $display("FAIL lh_addr: got %h want 80000000", t_mem_addr); end
    run32(0, 3'b101, 32'h8000_0002, 32'h0, 32'h8123_4567, 0, 0, 0, 0);
    checks++; if (t_rdata !== 32'h0000_8123) begin errors++; $display("FAIL lhu_rdata: got %h want 00008123", t_rdata); end
    run32(0, 3'b000, 32'h8000_0001, 32'h0, 32'h8123_4567, 0, 0, 0, 0);
    checks++; if (t_rdata !== 32'h0000_0045) begin errors++; $display("FAIL lb_off1: got %h want 00000045", t_rdata); end
    run32(0, 3'b000, 32'h8000_0003, 32'h0, 32'h8123_4567, 0, 0, 0, 0);
    checks++; if (t_rdata !== 32'hFFFF_FF81) begin errors++; $display("FAIL lb_off3: got %h want ffffff81", t_rdata); end
    run32(0, 3'b010, 32'h8000_0010, 32'h0, 32'h8123_4567, 0, 0, 0, 0);
    checks++; if (t_rdata !== 32'h8123_4567 || t_err !== 1'b0) begin errors++;
      $display("FAIL lw_rdata: got %h err=%b want 81234567/0", t_rdata, t_err); end
  endtask

  task automatic test_errors();
    run32(0, 3'b010, 32'h8000_0002, 32'h0, 32'h1111_1111, 0, 0, 0, 0);
    checks++; if (t_saw_mem !== 1'b0) begin errors++; $display("FAIL misalign_no_mem: got %b want 0", t_saw_mem); end
    checks++; if (t_err !== 1'b1 || t_rdata !== 32'h0) begin errors++;
      $display("FAIL misalign_resp: got err=%b rdata=%h want 1/0", t_err, t_rdata); end
    run32(0, 3'b011, 32'h8000_0000, 32'h0, 32'h1111_1111, 0, 0, 0, 0);
    checks++; if (t_err !== 1'b1 || t_saw_mem !== 1'b0) begin errors++;
      $display("FAIL f3_011_rv32: got err=%b mem=%b want 1/0", t_err, t_saw_mem); end
    run32(1, 3'b100, 32'h8000_0000, 32'h55, 32'h0, 0, 0, 0, 0);
    checks++; if (t_err !== 1'b1 || t_saw_mem !== 1'b0) begin errors++;
      $display("FAIL store_unsigned: got err=%b mem=%b want 1/0", t_err, t_saw_mem); end
    run32(0, 3'b010, 32'h8000_0000, 32'h0, 32'h2222_2222, 1, 0, 0, 0);
    checks++; if (t_saw_mem !== 1'b1 || t_err !== 1'b1 || t_rdata !== 32'h0) begin errors++;
      $display("FAIL bus_err: got mem=%b err=%b rdata=%h want 1/1/0", t_saw_mem, t_err, t_rdata); end
    run32(1, 3'b010, 32'h8000_0008, 32'h3333_3333, 32'h0, 1, 0, 0, 0);
    checks++; if (t_err !== 1'b1 || t_rdata !== 32'h0) begin errors++;
      $display("FAIL store_bus_err: got err=%b rdata=%h want 1/0", t_err, t_rdata); end
  endtask

  task automatic test_backpressure();
    run32(0, 3'b010, 32'h8000_0008, 32'h0, 32'hCAFE_F00D, 0, 5, 3, 2);
    checks++; if (t_mem_unstable !== 1'b0) begin errors++; $display("FAIL bp_mem_stable: got unstable=%b want 0", t_mem_unstable); end
    checks++; if (t_resp_unstable !== 1'b0) begin errors++; $display("FAIL bp_resp_stable: got unstable=%b want 0", t_resp_unstable); end
    checks++; if (t_req_ready_seen !== 1'b0) begin errors++; $display("FAIL bp_req_ready_low: got seen=%b want 0", t_req_ready_seen); end
    checks++; if (t_lat !== 11) begin errors++; $display("FAIL bp_latency: got %0d want 11", t_lat); end
    checks++; if (t_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL bp_rdata: got %h want cafef00d", t_rdata); end
  endtask

  task automatic test_reset_mid();
    int bad;
    req_valid = 1; req_wen = 0; req_funct3 = 3'b010; req_addr = 32'h8000_0000;
    tick();
    req_valid = 0; mem_req_ready = 1;
    tick();
    mem_req_ready = 0;
    checks++; if (mem_req_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin errors++;
      $display("FAIL mid_in_wait: got mv=%b rv=%b rr=%b want 0/0/0", mem_req_valid, resp_valid, req_ready); end
    rst = 1;
    #1;
    checks++; if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_err !== 1'b0 || resp_rdata !== 32'h0 ||
                  mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0 || mem_req_wmask !== 4'h0) begin errors++;
      $display("FAIL mid_reset_outputs: got rr=%b rv=%b re=%b rd=%h mv=%b ma=%h mm=%h", req_ready, resp_valid,
               resp_err, resp_rdata, mem_req_valid, mem_req_addr, mem_req_wmask); end
    @(negedge clk);
    rst = 0;
    tick();
    mem_rsp_valid = 1; mem_rsp_rdata = 32'h7777_7777;
    tick();
    mem_rsp_valid = 0;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_req_valid !== 1'b0) bad++;
      tick();
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL stray_rsp_ignored: got %0d bad cycles want 0", bad); end
  endtask

  task automatic test_xlen64();
    run64(3'b011, 32'h0000_0008, 64'h0123_4567_89AB_CDEF);
    checks++; if (d_rdata !== 64'h0123_4567_89AB_CDEF || d_err !== 1'b0) begin errors++;
      $display("FAIL rv64_ld: got %h err=%b want 0123456789abcdef/0", d_rdata, d_err); end
    checks++; if (d_addr !== 32'h8 || d_wmask !== 8'hFF) begin errors++;
      $display("FAIL rv64_ld_req: got addr=%h wmask=%h want 8/ff", d_addr, d_wmask); end
    run64(3'b010, 32'h0000_000C, 64'h8765_4321_0123_4567);
    checks++; if (d_rdata !== 64'hFFFF_FFFF_8765_4321 || d_addr !== 32'h8) begin errors++;
      $display("FAIL rv64_lw_hi: got %h addr=%h want ffffffff87654321/8", d_rdata, d_addr); end
    run64(3'b110, 32'h0000_000C, 64'h8765_4321_0123_4567);
    checks++; if (d_rdata !== 64'h0000_0000_8765_4321) begin errors++;
      $display("FAIL rv64_lwu: got %h want 0000000087654321", d_rdata); end
    run64(3'b111, 32'h0000_0000, 64'h0);
    checks++; if (d_err !== 1'b1 || d_saw_mem !== 1'b0 || d_rdata !== 64'h0) begin errors++;
      $display("FAIL rv64_f3_111: got err=%b mem=%b rdata=%h want 1/0/0", d_err, d_saw_mem, d_rdata); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_store_word();
    test_store_lanes();
    test_loads();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_xlen64();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
